// File: rtl/ccx_ic_arbiter.sv
// Two-into-one arbiter sharing the router's CPU-side port between instruction
// fetch (port A) and load/store (port B). The request path is combinational;
// a stalled selection is locked until granted, and the one-cycle response
// error is steered back to the owner of the accepted transaction.
module ccx_ic_arbiter #(
  parameter int unsigned AW         = 39,
  parameter int unsigned DW         = 64,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  // port A: instruction fetch requester
  input  logic            a_req,
  output logic            a_gnt,
  input  logic [AW-1:0]   a_addr,
  input  logic            a_wen,
  input  logic [DW/8-1:0] a_strb,
  input  logic [DW-1:0]   a_wdata,
  output logic [DW-1:0]   a_rdata,
  output logic            a_err,
  // port B: load/store requester
  input  logic            b_req,
  output logic            b_gnt,
  input  logic [AW-1:0]   b_addr,
  input  logic            b_wen,
  input  logic [DW/8-1:0] b_strb,
  input  logic [DW-1:0]   b_wdata,
  output logic [DW-1:0]   b_rdata,
  output logic            b_err,
  // shared port towards the router
  output logic            m_req,
  input  logic            m_gnt,
  output logic [AW-1:0]   m_addr,
  output logic            m_wen,
  output logic [DW/8-1:0] m_strb,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_err
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  logic  lock_vld;
  port_e lock_sel;
  port_e last_win;
  logic  rsp_vld;
  port_e rsp_sel;

  port_e sel;
  logic  lock_hit;
  logic  accept;
  logic  stall;

  // Winner selection: a stalled selection holds while its requester still asks;
  // a locked port that dropped req falls through to normal arbitration.
  always_comb begin
    sel      = PORT_A;
    lock_hit = lock_vld && ((lock_sel == PORT_A) ? a_req : b_req);
    if (lock_hit) begin
      sel = lock_sel;
    end else if (a_req && !b_req) begin
      sel = PORT_A;
    end else if (!a_req && b_req) begin
      sel = PORT_B;
    end else if (a_req && b_req) begin
      if (FIXED_PRIO) begin
        sel = PORT_A;
      end else begin
        sel = (last_win == PORT_A) ? PORT_B : PORT_A;
      end
    end
  end

  // Forward the selected request to the router and route the grant back;
  // reset suppresses every request, grant and error.
  always_comb begin
    m_req   = 1'b0;
    m_addr  = a_addr;
    m_wen   = a_wen;
    m_strb  = a_strb;
    m_wdata = a_wdata;
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    if (sel == PORT_B) begin
      m_addr  = b_addr;
      m_wen   = b_wen;
      m_strb  = b_strb;
      m_wdata = b_wdata;
    end
    if (g_resetn) begin
      m_req = (sel == PORT_A) ? a_req : b_req;
      a_gnt = (sel == PORT_A) && a_req && m_gnt;
      b_gnt = (sel == PORT_B) && b_req && m_gnt;
    end
  end

  assign accept = m_req && m_gnt;
  assign stall  = m_req && !m_gnt;

  // Response steering: read data is broadcast, error goes to the owner only.
  always_comb begin
    a_rdata = m_rdata;
    b_rdata = m_rdata;
    a_err   = 1'b0;
    b_err   = 1'b0;
    if (g_resetn && rsp_vld) begin
      a_err = (rsp_sel == PORT_A) && m_err;
      b_err = (rsp_sel == PORT_B) && m_err;
    end
  end

  // Lock, round-robin history and response ownership; last_win resets to B so
  // that A takes the first tie.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      lock_vld <= 1'b0;
      lock_sel <= PORT_A;
      last_win <= PORT_B;
      rsp_vld  <= 1'b0;
      rsp_sel  <= PORT_A;
    end else begin
      lock_vld <= stall;
      if (stall) begin
        lock_sel <= sel;
      end
      rsp_vld <= accept;
      if (accept) begin
        last_win <= sel;
        rsp_sel  <= sel;
      end
    end
  end

endmodule
